// File: rtl/mdsa_stream_host.sv
// Host-side initiator for the MDSA bitonic sorter: gathers a serial stream into an
// N x N matrix, launches a sort, captures the result and streams it back out row-major.
module mdsa_stream_host #(
   parameter int N       = 8,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [W-1:0]       in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [W-1:0]       out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic [N*N*W-1:0]   mat_load,
   input  logic [N*N*W-1:0]   mat_sorted,
   output logic               sorter_en,
   output logic               sorter_start,
   input  logic               sorter_ready,
   input  logic               sorter_oe,
   output logic               busy,
   output logic               timeout_err,
   output logic [1:0]         o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and data/last hold steady while valid is high and ready low.

   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } state_t;

   state_t             r_state;
   logic [IW-1:0]      r_idx;
   logic [IW-1:0]      r_uidx;
   logic [TW-1:0]      r_tcnt;
   logic [NE*W-1:0]    r_mat_load;
   logic [NE*W-1:0]    r_result;
   logic               r_out_valid;
   logic [W-1:0]       r_out_data;
   logic               r_out_last;
   logic               r_timeout_err;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_start;
   logic [IW-1:0]      w_uidx_next;
   logic [TW-1:0]      w_tcnt_next;
   logic [W-1:0]       w_next_elem;

   assign in_ready     = rst & (r_state == S_LOAD);
   assign w_in_fire    = in_valid & in_ready;
   assign w_out_fire   = r_out_valid & out_ready;
   // START is a decode of LAUNCH and READY so it lasts exactly the cycle READY is seen.
   assign w_start      = rst & (r_state == S_LAUNCH) & sorter_ready;
   assign w_uidx_next  = r_uidx + 1'b1;
   assign w_tcnt_next  = r_tcnt + 1'b1;
   assign w_next_elem  = r_result[int'(w_uidx_next)*W +: W];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_LOAD;
         r_idx         <= '0;
         r_uidx        <= '0;
         r_tcnt        <= '0;
         r_mat_load    <= '0;
         r_result      <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_last    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_in_fire) begin
                  r_mat_load[int'(r_idx)*W +: W] <= in_data;
                  if (r_idx == LAST_IDX) begin
                     r_idx   <= '0;
                     r_state <= S_LAUNCH;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end

            S_LAUNCH: begin
               if (w_start) begin
                  r_tcnt  <= '0;
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               // A capture in the same cycle as the last allowed count wins over the timeout.
               if (sorter_oe) begin
                  r_result    <= mat_sorted;
                  r_uidx      <= '0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= mat_sorted[W-1:0];
                  r_out_last  <= (LAST_IDX == '0);
                  r_state     <= S_UNLOAD;
               end else if (w_tcnt_next == TO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_idx         <= '0;
                  r_state       <= S_LOAD;
               end else begin
                  r_tcnt <= w_tcnt_next;
               end
            end

            S_UNLOAD: begin
               if (w_out_fire) begin
                  if (r_uidx == LAST_IDX) begin
                     r_uidx      <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_state     <= S_LOAD;
                  end else begin
                     r_uidx     <= w_uidx_next;
                     r_out_data <= w_next_elem;
                     r_out_last <= (w_uidx_next == LAST_IDX);
                  end
               end
            end

            default: begin
               r_state       <= S_LOAD;
               r_idx         <= '0;
               r_uidx        <= '0;
               r_tcnt        <= '0;
               r_mat_load    <= '0;
               r_out_valid   <= 1'b0;
               r_out_data    <= '0;
               r_out_last    <= 1'b0;
               r_timeout_err <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;
   assign mat_load     = r_mat_load;
   assign sorter_en    = rst;
   assign sorter_start = w_start;
   assign busy         = (r_state != S_LOAD);
   assign timeout_err  = r_timeout_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mdsa_stream_host.sv
// Bench for mdsa_stream_host: directed jobs, a behavioural sorter/controller model and
// a scoreboard monitor that checks every accepted output element against an expected queue.
module tb_mdsa_stream_host;

   localparam int N       = 8;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;
   localparam int NE      = N * N;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic [W-1:0]       in_data;
   logic               in_ready;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic               out_last;
   logic               out_ready;
   logic [NE*W-1:0]    mat_load;
   logic [NE*W-1:0]    mat_sorted;
   logic               sorter_en;
   logic               sorter_start;
   logic               sorter_ready;
   logic               sorter_oe;
   logic               busy;
   logic               timeout_err;
   logic [1:0]         dbg_state;

   mdsa_stream_host #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .mat_load     (mat_load),
      .mat_sorted   (mat_sorted),
      .sorter_en    (sorter_en),
      .sorter_start (sorter_start),
      .sorter_ready (sorter_ready),
      .sorter_oe    (sorter_oe),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .o_dbg_state  (dbg_state)
   );

   // ---------------- clock / reset / bookkeeping ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [W:0] exp_q[$];

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      failures = failures + 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- hand-computed job patterns ----------------
   function automatic logic [W-1:0] gen(input int pat, input int k);
      case (pat)
         0:       return W'(63 - k);
         1:       return W'(((k ^ 42) * 2) + 1);
         2:       return W'(255 - 2 * k);
         default: return W'(200 + k);
      endcase
   endfunction

   function automatic logic [W-1:0] exp_sorted(input int pat, input int j);
      case (pat)
         0:       return W'(j);
         1:       return W'(2 * j + 1);
         default: return W'(129 + 2 * j);
      endcase
   endfunction

   // ---------------- sorter / controller model ----------------
   logic [W-1:0] m_mat [NE];
   bit  m_active    = 1'b0;
   bit  m_oe_never  = 1'b0;
   bit  m_hold_low  = 1'b0;
   int  m_cnt       = 0;
   int  m_start_cnt = 0;
   int  oe_delay    = 40;

   initial begin
      logic s;
      logic [W-1:0] t;
      sorter_ready = 1'b0;
      sorter_oe    = 1'b0;
      mat_sorted   = '0;
      forever begin
         @(negedge clk);
         s = sorter_start;
         if (s) begin
            m_start_cnt = m_start_cnt + 1;
            for (int k = 0; k < NE; k++) m_mat[k] = mat_load[k*W +: W];
            for (int a = 1; a < NE; a++) begin
               for (int b = a; b > 0; b--) begin
                  if (m_mat[b] < m_mat[b-1]) begin
                     t = m_mat[b]; m_mat[b] = m_mat[b-1]; m_mat[b-1] = t;
                  end
               end
            end
         end
         @(posedge clk);
         #1;
         sorter_oe = 1'b0;
         if (s) begin
            m_active = 1'b1;
            m_cnt    = oe_delay;
         end else if (m_active && !m_oe_never) begin
            if (m_cnt <= 1) begin
               for (int k = 0; k < NE; k++) mat_sorted[k*W +: W] = m_mat[k];
               sorter_oe = 1'b1;
               m_active  = 1'b0;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
         sorter_ready = !m_active && !m_hold_low;
      end
   end

   // ---------------- downstream ready pattern (1,0,0 repeating when enabled) ----------------
   bit or_mode = 1'b0;
   initial begin
      int ph = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (or_mode) begin
            out_ready = (ph == 0);
            ph = (ph + 1) % 3;
         end else begin
            out_ready = 1'b1;
            ph = 0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   int ov_cycles   = 0;
   int overlap_bad = 0;
   int last_hs_cyc = -10;

   initial begin
      logic       prev_stall;
      logic [W:0] prev_out;
      logic [W:0] e;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (out_valid) ov_cycles = ov_cycles + 1;
            if (in_ready && busy) overlap_bad = overlap_bad + 1;
            if (prev_stall)
               check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", out_valid, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", out_data, e[W-1:0]);
                  check("out_last", out_last, e[W]);
                  if (out_last) last_hs_cyc = cyc;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_elem(input logic [W-1:0] d, output int acc_cyc);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && guard < 3000) begin
         guard = guard + 1;
         @(negedge clk);
      end
      if (!in_ready) check("accept_wait", in_ready, 1'b1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_job(input int pat, input int count, input bit expect_out,
                           input bit want_start, output int first_acc);
      logic [W:0]      e;
      logic [NE*W-1:0] v;
      int              acc;
      v = '0;
      first_acc = 0;
      if (expect_out) begin
         for (int j = 0; j < NE; j++) begin
            e[W]     = (j == NE - 1);
            e[W-1:0] = exp_sorted(pat, j);
            exp_q.push_back(e);
         end
      end
      for (int k = 0; k < count; k++) begin
         v[k*W +: W] = gen(pat, k);
         send_elem(gen(pat, k), acc);
         if (k == 0) first_acc = acc;
      end
      if (count == NE) begin
         @(negedge clk);
         checks = checks + 1;
         if (mat_load !== v) begin
            failures = failures + 1;
            $display("FAIL mat_load_pack actual=%0h required=%0h", mat_load, v);
         end
         check("start_after_last", sorter_start, want_start);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         guard = guard + 1;
         @(negedge clk);
      end
      if (exp_q.size() != 0) check(name, exp_q.size(), 0);
      @(negedge clk);
      check("idle_after_job", {busy, in_ready}, 2'b01);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"},  in_ready, 1'b0);
      check({tag, "_outs"},      {out_valid, out_last, out_data}, '0);
      check({tag, "_sorter"},    {sorter_start, sorter_en}, 2'b00);
      check({tag, "_busy_err"},  {busy, timeout_err, dbg_state}, '0);
      check({tag, "_mat_load"},  (mat_load == '0), 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int fa;
      int hi_cnt;
      int ov_before;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {in_ready, sorter_en, busy}, 3'b110);
      @(posedge clk);
      #1;

      // Job 1: descending input, free-running downstream.
      send_job(0, NE, 1'b1, 1'b1, fa);
      wait_drain("t1_drain");
      check("t1_start_pulses", m_start_cnt, 1);

      // Job 2: downstream ready 1,0,0 pattern.
      or_mode = 1'b1;
      send_job(1, NE, 1'b1, 1'b1, fa);
      wait_drain("t2_drain");
      or_mode = 1'b0;
      check("t2_start_pulses", m_start_cnt, 2);

      // Job 3: READY held low at LAUNCH for 10 cycles.
      m_hold_low = 1'b1;
      send_job(2, NE, 1'b1, 1'b0, fa);
      hi_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (sorter_start) hi_cnt = hi_cnt + 1;
      end
      check("t3_start_held", hi_cnt, 0);
      check("t3_busy_launch", {busy, dbg_state}, 3'b101);
      m_hold_low = 1'b0;
      wait_drain("t3_drain");
      check("t3_start_pulses", m_start_cnt, 3);

      // Job 4: oe never arrives, then a good job keeps the sticky error.
      m_oe_never = 1'b1;
      ov_before  = ov_cycles;
      send_job(1, NE, 1'b0, 1'b1, fa);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("t4_err_before", {timeout_err, busy}, 2'b01);
      @(negedge clk);
      check("t4_err_at_timeout", {timeout_err, in_ready, busy, dbg_state}, 5'b11000);
      check("t4_no_output", ov_cycles - ov_before, 0);
      m_active   = 1'b0;
      m_oe_never = 1'b0;
      @(posedge clk);
      #1;
      send_job(0, NE, 1'b1, 1'b1, fa);
      wait_drain("t4_drain");
      check("t4_err_sticky", timeout_err, 1'b1);

      // Job 5: reset after 20 stale elements, then a full job.
      send_job(3, 20, 1'b0, 1'b0, fa);
      rst = 1'b0;
      @(negedge clk);
      check("t5_en_low", sorter_en, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_state("t5_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      send_job(2, NE, 1'b1, 1'b1, fa);
      wait_drain("t5_drain");

      // Job 6: back-to-back, second job presented during unload.
      overlap_bad = 0;
      send_job(0, NE, 1'b1, 1'b1, fa);
      send_job(1, NE, 1'b1, 1'b1, fa);
      check("t6_first_accept", fa, last_hs_cyc + 1);
      wait_drain("t6_drain");
      check("t6_ready_while_busy", overlap_bad, 0);

      check("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdsa_stream_host.md
Name: mdsa_stream_host

Overview:
- Host-side initiator for the MDSA bitonic sorter array and its phase controller.
- Accepts a serial element stream and assembles an N×N matrix onto the parallel sorter load bus.
- Issues a single-cycle START when the controller reports READY, then waits for the controller's output_enable pulse and captures the sorted matrix.
- Streams the sorted matrix back out, row-major, with valid/ready backpressure.

Parameters:
- N, 8, matrix dimension (rows = columns); N*N elements per sort job.
- W, 8, element width in bits.
- TIMEOUT, 64, maximum cycles from START to output_enable before the job is aborted.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_data  in  W  input element.
- in_ready  out  1  block accepts an element this cycle.
- out_valid  out  1  sorted element valid.
- out_data  out  W  sorted element.
- out_last  out  1  marks element N*N-1 of the job.
- out_ready  in  1  downstream accepts out_data.
- mat_load  out  N*N*W  matrix to the sorter; element k occupies bits [k*W +: W], k = row*N + col.
- mat_sorted  in  N*N*W  sorter result bus, same packing.
- sorter_en  out  1  enable to the controller.
- sorter_start  out  1  START to the controller.
- sorter_ready  in  1  controller READY.
- sorter_oe  in  1  controller output_enable, a 1-cycle pulse when the result is valid.
- busy  out  1  high in any state other than LOAD.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=LOAD; load and unload indices = 0; mat_load = 0; result register = 0.
  - in_ready=0 during the reset cycle; it rises the first cycle after reset.
  - out_valid=0, out_last=0, out_data=0, sorter_start=0, sorter_en=0, busy=0, timeout_err=0.
  - Reset mid-job aborts the job. No START is issued and no output is produced for the partial data.
- sorter_en=1 in every cycle where rst=1.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, write in_data into element idx and increment idx.
  - On accepting element N*N-1: idx wraps to 0 and the next state is LAUNCH.
  - Element count uses an unsigned counter of width clog2(N*N). It never exceeds N*N-1.
- LAUNCH:
  - in_ready=0.
  - When sorter_ready=1: sorter_start=1 for exactly that cycle; the timeout counter clears; next state is WAIT_SORT.
  - When sorter_ready=0: hold in LAUNCH with start=0.
- WAIT_SORT:
  - sorter_start=0 and sorter_ready is ignored, because READY may lag START by one or more cycles.
  - Timeout counter increments each cycle.
  - On sorter_oe=1: capture mat_sorted into the result register; next state is UNLOAD. The unload index is 0.
  - If the counter reaches TIMEOUT-1 without oe: set timeout_err=1 (sticky until reset) and go to LOAD. mat_load is retained; idx=0.
  - If oe arrives in the same cycle the counter hits TIMEOUT-1, the capture wins and no error is raised.
- UNLOAD:
  - out_valid=1; out_data = result element uidx.
  - out_last = (uidx==N*N-1).
  - out_data and out_last are held stable while out_ready=0.
  - On out_valid&out_ready: uidx increments. On the last element, next state is LOAD and in_ready=1 on the following cycle.
  - sorter_oe pulses outside WAIT_SORT are ignored.
- Latency: START occurs at the earliest on the cycle after the last input is accepted. First out_valid is the cycle after the sorter_oe pulse.
- Other states:
  - in_ready=0 in every state except LOAD; in_valid is ignored there with no side effects.
  - out_valid=0 in every state except UNLOAD.
- Unused state encodings recover to LOAD with all outputs at reset values.

Test Plan:
1. Load 64 elements 63,62,…,0 with in_valid held high; sorter model holds READY=1, drops READY the cycle after START, and pulses oe after 40 cycles with the ascending result → exactly one 1-cycle START pulse, first issued the cycle after element 63 is accepted. Output is 0..63 in order, out_last only on value 63, busy=0 afterwards.
2. Backpressure: out_ready toggles 1,0,0,1,… during unload → no element is dropped or duplicated, and out_data is stable across stalls. All 64 elements are received in order.
3. READY low at LAUNCH for 10 cycles → sorter_start stays 0 until READY rises, then pulses for exactly 1 cycle.
4. Timeout: sorter model never pulses oe → timeout_err=1 exactly TIMEOUT cycles after START, state returns to LOAD (in_ready=1), and no out_valid occurs. A later successful job leaves timeout_err=1.
5. Reset mid-load after 20 elements → all outputs go to reset values. A following full 64-element job sorts correctly and contains none of the stale 20 elements.
6. Back-to-back jobs with in_valid asserted during UNLOAD → in_ready=0 until the last output is accepted. The second job's first element is accepted the cycle after, and both jobs produce correct sorted output.
